arm_ctrl_fsm: RTL and testbench
===============================

Name: arm_ctrl_fsm

Overview:
Multicycle ARM control unit: the main FSM plus the instruction decode logic. It drives the per-step control strobes (NextPC, RegW, MemW, FlagW, PCS) that the condition-logic block gates with CondEx, and it drives the datapath mux selects. Inputs are the Op/Funct/Rd fields of the latched instruction register. It sits between the instruction register and condition logic in the controller.

Parameters:
none

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
Op  in  2  Instr[27:26]
Funct  in  6  Instr[25:20]; [5]=I, [4:1]=cmd, [0]=S/L
Rd  in  4  Instr[15:12]
state  out  4  current FSM state (debug/verification)
IRWrite  out  1  instruction register load
AdrSrc  out  1  0=PC, 1=ALU result as memory address
ALUSrcA  out  1  0=RD1, 1=PC
ALUSrcB  out  2  00=RD2/shifted, 01=ExtImm, 10=constant 4
ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
ImmSrc  out  2  equals Op
RegSrc  out  2  [0]=(Op==10), [1]=(Op==01)
NextPC  out  1  unconditional PC write (fetch)
RegW  out  1  register write request, pre-condition
MemW  out  1  memory write request, pre-condition
FlagW  out  2  [1]=N,Z write, [0]=C,V write, pre-condition
PCS  out  1  conditional PC write request

Behaviour:
- One clock domain. Synchronous active-high reset forces state=FETCH (0). Outputs are Moore-decoded from state and therefore show FETCH values in the cycle after reset.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, UNKNOWN=10. Codes 11-15 are illegal and go to FETCH.
- Transitions:
  - FETCH->DECODE.
  - DECODE: Op=01 -> MEMADR; Op=00 with Funct[5]=0 -> EXECUTER; Op=00 with Funct[5]=1 -> EXECUTEI; Op=10 -> BRANCH; Op=11 -> UNKNOWN.
  - MEMADR: Funct[0]=1 -> MEMRD, else MEMWR.
  - MEMRD->MEMWB->FETCH. MEMWR->FETCH.
  - EXECUTER/EXECUTEI->ALUWB->FETCH. BRANCH->FETCH. UNKNOWN->FETCH.
- Per-state outputs (unlisted = 0):
  - FETCH: IRWrite=1, NextPC=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, AdrSrc=0.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcA=0, ALUSrcB=01.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, MemW=1.
  - EXECUTER: ALUSrcB=00, ALUOp=1.
  - EXECUTEI: ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1 (internal).
  - UNKNOWN: all zero.
- ALU decode:
  - With ALUOp=0: ALUControl=00, FlagW=00.
  - With ALUOp=1, Funct[4:1]: 0100->00, 0010->01, 0000->10, 1100->11. Any other cmd -> ALUControl=00, FlagW=00.
  - For supported cmds: FlagW[1]=Funct[0]; FlagW[0]=Funct[0]&(ADD|SUB).
- FlagW is asserted only in EXECUTER/EXECUTEI, never in ALUWB. Flags therefore update one cycle before the writeback.
- PCS = (Rd==1111 & RegW) | Branch. It is asserted in MEMWB/ALUWB when Rd=15, and in BRANCH.
- ImmSrc and RegSrc are purely combinational from Op and valid in every state.
- Instruction fields are sampled each cycle. The controller relies on IR holding stable after FETCH and adds no field latching of its own.
- Reset asserted in any state returns to FETCH at the next edge. No partial write strobe may be emitted in that cycle, because outputs follow the registered state.

Test Plan:
- Reset held 2 cycles, then released -> state=0, IRWrite=1, NextPC=1, ALUSrcB=10, ResultSrc=10. Next cycle state=1 with all strobes 0.
- LDR (Op=01, Funct=011001, Rd=3) -> states 0,1,2,3,4,0. AdrSrc=1 in MEMRD. MEMWB: RegW=1, ResultSrc=01, PCS=0. Cycle count = 5.
- STR (Op=01, Funct=011000) -> states 0,1,2,5,0. MEMWR: MemW=1, AdrSrc=1. RegW is never 1.
- Arithmetic with flags:
  - SUBS reg (Op=00, Funct=000101, Rd=2) -> EXECUTER: ALUControl=01, FlagW=11. Then ALUWB: RegW=1, FlagW=00.
  - ORRS imm (Funct=111001) -> EXECUTEI: ALUControl=11, FlagW=10, ALUSrcB=01.
- Writes to PC:
  - ADD with Rd=1111 -> ALUWB: RegW=1, PCS=1.
  - B (Op=10) -> BRANCH: PCS=1, ALUSrcB=01, ResultSrc=10, RegW=0. Then FETCH.
- Robustness:
  - Op=11 -> DECODE, UNKNOWN (all strobes 0), FETCH.
  - Unsupported cmd Funct[4:1]=1111 with S=1 -> FlagW=00.
  - Reset asserted during MEMRD -> state=0 next cycle, MemW/RegW=0.

Source files
------------

// File: rtl/arm_ctrl_fsm.sv
// arm_ctrl_fsm: multicycle ARM main controller FSM plus ALU/flag decode.
// Latency: Moore outputs, valid in the same cycle the state is registered; one state per clock.
// Backpressure: none; advances every cycle and relies on the IR holding stable after FETCH.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset (-> FETCH)
//   Op, Funct, Rd        instruction fields from the latched instruction register
//   state                current FSM state code (debug/verification)
//   IRWrite, AdrSrc,
//   ALUSrcA, ALUSrcB,
//   ResultSrc            datapath load enable and mux selects
//   ALUControl           00 ADD, 01 SUB, 10 AND, 11 ORR
//   ImmSrc, RegSrc       combinational decode of Op, valid in every state
//   NextPC               unconditional PC write during fetch
//   RegW, MemW, FlagW,
//   PCS                  write requests, later gated by CondEx in the condition logic
module arm_ctrl_fsm (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic [3:0] Rd,
   output logic [3:0] state,
   output logic       IRWrite,
   output logic       AdrSrc,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUControl,
   output logic [1:0] ImmSrc,
   output logic [1:0] RegSrc,
   output logic       NextPC,
   output logic       RegW,
   output logic       MemW,
   output logic [1:0] FlagW,
   output logic       PCS
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMRD    = 4'd3,
      MEMWB    = 4'd4,
      MEMWR    = 4'd5,
      EXECUTER = 4'd6,
      EXECUTEI = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9,
      UNKNOWN  = 4'd10
   } state_t;

   state_t state_q;
   state_t state_d;

   // Internal strobes: aluop enables the ALU/flag decode, branch feeds PCS.
   logic aluop;
   logic branch;

   // ---------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   assign state = state_q;

   // ---------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------
   always_comb begin
      state_d = FETCH;
      case (state_q)
         FETCH:  state_d = DECODE;
         DECODE: begin
            case (Op)
               2'b00:   state_d = Funct[5] ? EXECUTEI : EXECUTER;
               2'b01:   state_d = MEMADR;
               2'b10:   state_d = BRANCH;
               default: state_d = UNKNOWN;
            endcase
         end
         // Funct[0] is the L bit for memory instructions.
         MEMADR:   state_d = Funct[0] ? MEMRD : MEMWR;
         MEMRD:    state_d = MEMWB;
         MEMWB:    state_d = FETCH;
         MEMWR:    state_d = FETCH;
         EXECUTER: state_d = ALUWB;
         EXECUTEI: state_d = ALUWB;
         ALUWB:    state_d = FETCH;
         BRANCH:   state_d = FETCH;
         UNKNOWN:  state_d = FETCH;
         // Codes 11-15 are not reachable from reset but recover to FETCH.
         default:  state_d = FETCH;
      endcase
   end

   // ---------------------------------------------------------------
   // Moore output decode
   // ---------------------------------------------------------------
   always_comb begin
      IRWrite   = 1'b0;
      AdrSrc    = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 2'b00;
      ResultSrc = 2'b00;
      NextPC    = 1'b0;
      RegW      = 1'b0;
      MemW      = 1'b0;
      aluop     = 1'b0;
      branch    = 1'b0;
      case (state_q)
         FETCH: begin
            IRWrite   = 1'b1;
            NextPC    = 1'b1;
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
         end
         // PC+8 is formed here so R15 reads see the architectural value.
         DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
         end
         MEMADR: begin
            ALUSrcB = 2'b01;
         end
         MEMRD: begin
            AdrSrc = 1'b1;
         end
         MEMWB: begin
            ResultSrc = 2'b01;
            RegW      = 1'b1;
         end
         MEMWR: begin
            AdrSrc = 1'b1;
            MemW   = 1'b1;
         end
         EXECUTER: begin
            aluop = 1'b1;
         end
         EXECUTEI: begin
            ALUSrcB = 2'b01;
            aluop   = 1'b1;
         end
         ALUWB: begin
            RegW = 1'b1;
         end
         BRANCH: begin
            ALUSrcB   = 2'b01;
            ResultSrc = 2'b10;
            branch    = 1'b1;
         end
         default: begin
            // UNKNOWN and illegal codes: everything stays at its default of 0.
         end
      endcase
   end

   // ---------------------------------------------------------------
   // ALU and flag-write decode
   // Flags are only requested while aluop is high (EXECUTE states), so
   // they update one cycle ahead of the ALUWB register write.
   // ---------------------------------------------------------------
   always_comb begin
      ALUControl = 2'b00;
      FlagW      = 2'b00;
      if (aluop) begin
         case (Funct[4:1])
            4'b0100: begin   // ADD
               ALUControl = 2'b00;
               FlagW      = {Funct[0], Funct[0]};
            end
            4'b0010: begin   // SUB
               ALUControl = 2'b01;
               FlagW      = {Funct[0], Funct[0]};
            end
            4'b0000: begin   // AND: logical ops leave C,V alone
               ALUControl = 2'b10;
               FlagW      = {Funct[0], 1'b0};
            end
            4'b1100: begin   // ORR
               ALUControl = 2'b11;
               FlagW      = {Funct[0], 1'b0};
            end
            default: begin
               // Unsupported cmd: no ALU function selected, no flag update.
               ALUControl = 2'b00;
               FlagW      = 2'b00;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------
   // Combinational field decode and PC-write request
   // ---------------------------------------------------------------
   assign ImmSrc = Op;
   assign RegSrc = {(Op == 2'b01), (Op == 2'b10)};

   // A register write to R15 is a PC write; branches always request one.
   assign PCS = ((Rd == 4'hF) & RegW) | branch;

endmodule

// File: tb/tb_arm_ctrl_fsm.sv
// tb_arm_ctrl_fsm: directed self-checking bench for the multicycle ARM controller.
// Latency: inputs driven and outputs sampled on the falling edge, one state per clock.
// Backpressure: not applicable; the controller free-runs.
module tb_arm_ctrl_fsm;

   logic       clk;
   logic       reset;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic [3:0] Rd;
   logic [3:0] state;
   logic       IRWrite;
   logic       AdrSrc;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ResultSrc;
   logic [1:0] ALUControl;
   logic [1:0] ImmSrc;
   logic [1:0] RegSrc;
   logic       NextPC;
   logic       RegW;
   logic       MemW;
   logic [1:0] FlagW;
   logic       PCS;

   int tests_run;
   int tests_failed;

   // {IRWrite, NextPC, RegW, MemW, FlagW[1:0], PCS}
   logic [6:0] strb;
   // {AdrSrc, ALUSrcA, ALUSrcB[1:0], ResultSrc[1:0]}
   logic [5:0] mux;
   assign strb = {IRWrite, NextPC, RegW, MemW, FlagW, PCS};
   assign mux  = {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc};

   localparam logic [6:0] STRB_FETCH = 7'b1100000;
   localparam logic [5:0] MUX_FETCH  = 6'b0_1_10_10;

   arm_ctrl_fsm dut (
      .clk        (clk),
      .reset      (reset),
      .Op         (Op),
      .Funct      (Funct),
      .Rd         (Rd),
      .state      (state),
      .IRWrite    (IRWrite),
      .AdrSrc     (AdrSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ResultSrc  (ResultSrc),
      .ALUControl (ALUControl),
      .ImmSrc     (ImmSrc),
      .RegSrc     (RegSrc),
      .NextPC     (NextPC),
      .RegW       (RegW),
      .MemW       (MemW),
      .FlagW      (FlagW),
      .PCS        (PCS)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one state and land on the falling edge for sampling/driving.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      Op = 2'b00; Funct = 6'b0; Rd = 4'h0;
      step();
      step();
      reset = 1'b0;
      tests_run++;
      if (state !== 4'd0) begin
         tests_failed++;
         $display("FAIL reset_state: got %0d want 0", state);
      end
      tests_run++;
      if (strb !== STRB_FETCH || mux !== MUX_FETCH) begin
         tests_failed++;
         $display("FAIL reset_fetch_outputs: strb=%b mux=%b want strb=%b mux=%b",
                  strb, mux, STRB_FETCH, MUX_FETCH);
      end
      step();
      tests_run++;
      if (state !== 4'd1 || strb !== 7'b0 || mux !== 6'b0_1_10_10) begin
         tests_failed++;
         $display("FAIL reset_decode: state=%0d strb=%b mux=%b want 1 0000000 011010",
                  state, strb, mux);
      end
      // Let the Op=00 Funct=0 instruction finish: EXECUTER, ALUWB, FETCH.
      step(); step(); step();
   endtask

   task automatic test_ldr();
      int cycles;
      Op = 2'b01; Funct = 6'b011001; Rd = 4'd3;
      step(); // DECODE
      tests_run++;
      if (ImmSrc !== 2'b01 || RegSrc !== 2'b10) begin
         tests_failed++;
         $display("FAIL ldr_field_decode: ImmSrc=%b RegSrc=%b want 01 10", ImmSrc, RegSrc);
      end
      step(); // MEMADR
      tests_run++;
      if (state !== 4'd2 || mux !== 6'b0_0_01_00 || strb !== 7'b0) begin
         tests_failed++;
         $display("FAIL ldr_memadr: state=%0d mux=%b strb=%b want 2 000100 0000000",
                  state, mux, strb);
      end
      step(); // MEMRD
      tests_run++;
      if (state !== 4'd3 || AdrSrc !== 1'b1 || strb !== 7'b0) begin
         tests_failed++;
         $display("FAIL ldr_memrd: state=%0d AdrSrc=%b strb=%b want 3 1 0000000",
                  state, AdrSrc, strb);
      end
      step(); // MEMWB
      tests_run++;
      if (state !== 4'd4 || strb !== 7'b0010000 || ResultSrc !== 2'b01) begin
         tests_failed++;
         $display("FAIL ldr_memwb: state=%0d strb=%b ResultSrc=%b want 4 0010000 01",
                  state, strb, ResultSrc);
      end
      step();
      tests_run++;
      if (state !== 4'd0) begin
         tests_failed++;
         $display("FAIL ldr_return: state=%0d want 0", state);
      end
      // Count a second LDR from FETCH back to FETCH, bounded.
      cycles = 0;
      do begin
         step();
         cycles++;
      end while (state !== 4'd0 && cycles < 20);
      tests_run++;
      if (cycles !== 5) begin
         tests_failed++;
         $display("FAIL ldr_cycle_count: got %0d want 5", cycles);
      end
   endtask

   task automatic test_str();
      logic saw_regw;
      saw_regw = 1'b0;
      Op = 2'b01; Funct = 6'b011000; Rd = 4'd4;
      step(); saw_regw |= RegW; // DECODE
      step(); saw_regw |= RegW; // MEMADR
      step(); saw_regw |= RegW; // MEMWR
      tests_run++;
      if (state !== 4'd5 || strb !== 7'b0001000 || AdrSrc !== 1'b1) begin
         tests_failed++;
         $display("FAIL str_memwr: state=%0d strb=%b AdrSrc=%b want 5 0001000 1",
                  state, strb, AdrSrc);
      end
      step(); saw_regw |= RegW;
      tests_run++;
      if (state !== 4'd0 || saw_regw !== 1'b0) begin
         tests_failed++;
         $display("FAIL str_return: state=%0d saw_regw=%b want 0 0", state, saw_regw);
      end
   endtask

   task automatic test_subs();
      Op = 2'b00; Funct = 6'b000101; Rd = 4'd2;
      step(); step(); // EXECUTER
      tests_run++;
      if (state !== 4'd6 || ALUControl !== 2'b01 || strb !== 7'b0000110 || ALUSrcB !== 2'b00) begin
         tests_failed++;
         $display("FAIL subs_executer: state=%0d ALUControl=%b strb=%b ALUSrcB=%b want 6 01 0000110 00",
                  state, ALUControl, strb, ALUSrcB);
      end
      step(); // ALUWB
      tests_run++;
      if (state !== 4'd8 || strb !== 7'b0010000 || ResultSrc !== 2'b00) begin
         tests_failed++;
         $display("FAIL subs_aluwb: state=%0d strb=%b ResultSrc=%b want 8 0010000 00",
                  state, strb, ResultSrc);
      end
      step();
   endtask

   task automatic test_orrs();
      Op = 2'b00; Funct = 6'b111001; Rd = 4'd5;
      step(); step(); // EXECUTEI
      tests_run++;
      if (state !== 4'd7 || ALUControl !== 2'b11 || FlagW !== 2'b10 || ALUSrcB !== 2'b01) begin
         tests_failed++;
         $display("FAIL orrs_executei: state=%0d ALUControl=%b FlagW=%b ALUSrcB=%b want 7 11 10 01",
                  state, ALUControl, FlagW, ALUSrcB);
      end
      step(); step();
   endtask

   task automatic test_add_pc();
      Op = 2'b00; Funct = 6'b001000; Rd = 4'hF;
      step(); step(); // EXECUTER
      tests_run++;
      if (ALUControl !== 2'b00 || strb !== 7'b0) begin
         tests_failed++;
         $display("FAIL add_pc_executer: ALUControl=%b strb=%b want 00 0000000", ALUControl, strb);
      end
      step(); // ALUWB
      tests_run++;
      if (state !== 4'd8 || strb !== 7'b0010001) begin
         tests_failed++;
         $display("FAIL add_pc_aluwb: state=%0d strb=%b want 8 0010001", state, strb);
      end
      step();
   endtask

   task automatic test_branch();
      Op = 2'b10; Funct = 6'b000000; Rd = 4'h0;
      step(); step(); // BRANCH
      tests_run++;
      if (state !== 4'd9 || strb !== 7'b0000001 || mux !== 6'b0_0_01_10) begin
         tests_failed++;
         $display("FAIL branch_state: state=%0d strb=%b mux=%b want 9 0000001 000110",
                  state, strb, mux);
      end
      tests_run++;
      if (ImmSrc !== 2'b10 || RegSrc !== 2'b01) begin
         tests_failed++;
         $display("FAIL branch_field_decode: ImmSrc=%b RegSrc=%b want 10 01", ImmSrc, RegSrc);
      end
      step();
      tests_run++;
      if (state !== 4'd0 || strb !== STRB_FETCH) begin
         tests_failed++;
         $display("FAIL branch_return: state=%0d strb=%b want 0 1100000", state, strb);
      end
   endtask

   task automatic test_unknown();
      Op = 2'b11; Funct = 6'b001001; Rd = 4'hF;
      step(); step(); // UNKNOWN
      tests_run++;
      if (state !== 4'd10 || strb !== 7'b0 || mux !== 6'b0 || ALUControl !== 2'b00) begin
         tests_failed++;
         $display("FAIL unknown_state: state=%0d strb=%b mux=%b ALUControl=%b want 10 0 0 0",
                  state, strb, mux, ALUControl);
      end
      tests_run++;
      if (ImmSrc !== 2'b11 || RegSrc !== 2'b00) begin
         tests_failed++;
         $display("FAIL unknown_field_decode: ImmSrc=%b RegSrc=%b want 11 00", ImmSrc, RegSrc);
      end
      step();
      tests_run++;
      if (state !== 4'd0) begin
         tests_failed++;
         $display("FAIL unknown_return: state=%0d want 0", state);
      end
   endtask

   task automatic test_unsupported();
      Op = 2'b00; Funct = 6'b011111; Rd = 4'd1;
      step(); step(); // EXECUTER
      tests_run++;
      if (state !== 4'd6 || FlagW !== 2'b00 || ALUControl !== 2'b00) begin
         tests_failed++;
         $display("FAIL unsupported_cmd: state=%0d FlagW=%b ALUControl=%b want 6 00 00",
                  state, FlagW, ALUControl);
      end
      step(); step();
   endtask

   task automatic test_reset_midflight();
      Op = 2'b01; Funct = 6'b011001; Rd = 4'd7;
      step(); step(); step(); // MEMRD
      tests_run++;
      if (state !== 4'd3) begin
         tests_failed++;
         $display("FAIL midreset_reach_memrd: state=%0d want 3", state);
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      tests_run++;
      if (state !== 4'd0 || strb !== STRB_FETCH) begin
         tests_failed++;
         $display("FAIL midreset_fetch: state=%0d strb=%b want 0 1100000", state, strb);
      end
      step();
      tests_run++;
      if (state !== 4'd1 || MemW !== 1'b0 || RegW !== 1'b0) begin
         tests_failed++;
         $display("FAIL midreset_after: state=%0d MemW=%b RegW=%b want 1 0 0", state, MemW, RegW);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset = 1'b1;
      Op = 2'b00; Funct = 6'b0; Rd = 4'h0;
      @(negedge clk);
      test_reset();
      test_ldr();
      test_str();
      test_subs();
      test_orrs();
      test_add_pc();
      test_branch();
      test_unknown();
      test_unsupported();
      test_reset_midflight();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
